mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 37 +++
 rtl/mem_lane_align.sv | 41 ++++
 rtl/mem_responder.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types for the memory responder: access-size codes, FSM states, request record.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mem_pkg;

  // RV32 funct3 load/store access codes
  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Bit n set means funct3 code n is a legal load code (000,001,010,100,101)
  localparam logic [7:0] SIZE_LEGAL = 8'h37;

  // Latched request record
  typedef struct packed {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // Unsigned codes have no store form, so BU/HU with we=1 are rejected too
  function automatic logic size_ok(input logic [2:0] sz, input logic we);
    size_ok = SIZE_LEGAL[sz] && !(we && sz[2]);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte-enables/shifted data and load extraction/extension.
// Latency: purely combinational.
// Backpressure: none; misaligned offsets are rounded down to natural alignment here.
import mem_pkg::*;

module mem_lane_align (
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata
);

  logic [1:0]  off;
  logic [31:0] rsh;

  // Aligned lane offset, byte-enables, write-data placement and load extension
  always_comb begin
    off   = addr_lo;
    be    = 4'b0000;
    rdata = 32'h0;
    case (size)
      SZ_H, SZ_HU: off = {addr_lo[1], 1'b0};
      SZ_W:        off = 2'b00;
      default:     off = addr_lo;
    endcase
    wword = wdata << {off, 3'b000};
    rsh   = rword >> {off, 3'b000};
    case (size)
      SZ_B:  begin be = 4'b0001 << off; rdata = {{24{rsh[7]}}, rsh[7:0]};   end
      SZ_BU: begin be = 4'b0001 << off; rdata = {24'h0, rsh[7:0]};          end
      SZ_H:  begin be = 4'b0011 << off; rdata = {{16{rsh[15]}}, rsh[15:0]}; end
      SZ_HU: begin be = 4'b0011 << off; rdata = {16'h0, rsh[15:0]};         end
      SZ_W:  begin be = 4'b1111;        rdata = rword;                      end
      default: begin be = 4'b0000;      rdata = 32'h0;                      end
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding load/store responder over a word array (MEM_MISALIGN_CHECK_EN rejects misaligned H/W).
// Latency: rsp_valid rises WAIT_STATES+1 cycles after request acceptance.
// Backpressure: req_ready low from acceptance until the response handshake; response held while rsp_ready=0.
import mem_pkg::*;

module mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  state_e      state;
  logic [3:0]  cnt;
  req_t        req_q;
  logic [AW-1:0] idx;
  logic        misalign;
  logic        err;
  logic        access;
  logic [3:0]  be;
  logic [31:0] wword;
  logic [31:0] ld_data;

  assign idx    = req_q.addr[AW+1:2];
  assign access = reset && (state == ST_WAIT) && (cnt == 4'd0);

  // Alignment screening for halfword/word accesses when the check is built in
  always_comb begin
    misalign = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
    case (req_q.size)
      SZ_H, SZ_HU: misalign = req_q.addr[0];
      SZ_W:        misalign = (req_q.addr[1:0] != 2'b00);
      default:     misalign = 1'b0;
    endcase
`else
    misalign = 1'b0;
`endif
  end

  assign err = !size_ok(req_q.size, req_q.we) || misalign;

  mem_lane_align u_align (
    .size    (req_q.size),
    .addr_lo (req_q.addr[1:0]),
    .wdata   (req_q.wdata),
    .rword   (mem[idx]),
    .be      (be),
    .wword   (wword),
    .rdata   (ld_data)
  );

  // Storage write: only addressed lanes, only in the access cycle, never touched by reset
  always_ff @(posedge clock) begin
    if (access && req_q.we && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  // Request/response FSM with registered handshake outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      req_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            req_q     <= '{we: req_we, size: req_size, addr: req_addr, wdata: req_wdata};
            cnt       <= 4'(WAIT_STATES);
            req_ready <= 1'b0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            rsp_valid <= 1'b1;
            rsp_err   <= err;
            rsp_rdata <= (!req_q.we && !err) ? ld_data : 32'h0;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
